// File: rtl/keypad_pkg.sv
// Shared constants for the keypad time/alarm entry controller: key codes,
// display encodings, FSM state type and a two-digit decode helper.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_VIEW  = 2'b01;
  localparam state_t ST_ENTRY = 2'b10;
  localparam state_t ST_ERR   = 2'b11;

  localparam logic [1:0] DISP_TIME  = 2'b00;
  localparam logic [1:0] DISP_ALARM = 2'b01;
  localparam logic [1:0] DISP_ENTRY = 2'b10;
  localparam logic [1:0] DISP_ERROR = 2'b11;

  localparam logic [3:0] KEY_AMPM  = 4'hA;
  localparam logic [3:0] KEY_TIME  = 4'hB;
  localparam logic [3:0] KEY_ALARM = 4'hC;
  localparam logic [3:0] KEY_BACK  = 4'hD;
  localparam logic [3:0] KEY_NEXT  = 4'hE;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  // Full 7-bit value so out-of-range entries like 94 stay detectable.
  function automatic logic [6:0] two_digit(input logic [3:0] hi, input logic [3:0] lo);
    return 7'(hi) * 7'd10 + 7'(lo);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers the key level and turns it into single-cycle press/release pulses.
module key_edge_detect (
  input  logic Clock_1sec,
  input  logic reset,
  input  logic key_held,
  output logic key_press,
  output logic key_release
);

  logic held_q;

  always_ff @(posedge Clock_1sec or posedge reset) begin
    if (reset) held_q <= 1'b0;
    else       held_q <= key_held;
  end

  assign key_press   = key_held & ~held_q;
  assign key_release = ~key_held & held_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects up to four digits, validates them as
// HH:MM and pulses a load into the time of day or the selected alarm slot.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int NUM_ALARMS = 2,
  parameter int TIMEOUT    = 10,
  parameter int SLOT_W     = 3
) (
  input  logic              Clock_1sec,
  input  logic              reset,
  input  logic [3:0]        key_code,
  input  logic              key_held,
  input  logic              mode_24h,
  output logic              load_time,
  output logic              load_alarm,
  output logic [SLOT_W-1:0] load_slot,
  output logic [SLOT_W-1:0] alarm_slot,
  output logic [4:0]        set_hours,
  output logic [5:0]        set_mins,
  output logic [5:0]        set_secs,
  output logic              set_am_pm,
  output logic [1:0]        display_state,
  output logic [2:0]        input_count,
  output logic              entry_error
);

  logic        key_press, key_release;
  state_t      state, state_n;
  logic [15:0] digits, digits_n;
  logic [3:0]  tcnt, tcnt_n;
  logic        err_cnt, err_n;
  logic        am_pm_q, am_pm_n;
  logic        ampm_clr, clr_n;
  logic [2:0]  count_n;
  logic [SLOT_W-1:0] slot_n, ld_slot_n, slot_next;
  logic        ld_time_n, ld_alarm_n, err_pulse_n, hm_upd;
  logic [6:0]  hours_full, mins_full;
  logic [4:0]  hours_n;
  logic [5:0]  mins_n;
  logic        entry_valid;

  key_edge_detect u_edge (
    .Clock_1sec (Clock_1sec),
    .reset      (reset),
    .key_held   (key_held),
    .key_press  (key_press),
    .key_release(key_release)
  );

  assign hours_full  = two_digit(digits[15:12], digits[11:8]);
  assign mins_full   = two_digit(digits[7:4], digits[3:0]);
  assign entry_valid = (mins_full <= 7'd59) &&
                       (mode_24h ? (hours_full <= 7'd23)
                                 : (hours_full >= 7'd1 && hours_full <= 7'd12));
  assign slot_next   = (alarm_slot == SLOT_W'(NUM_ALARMS - 1)) ? '0 : alarm_slot + 1'b1;
  assign hours_n     = 5'(two_digit(digits_n[15:12], digits_n[11:8]));
  assign mins_n      = 6'(two_digit(digits_n[7:4], digits_n[3:0]));

  always_comb begin
    state_n     = state;
    digits_n    = digits;
    count_n     = input_count;
    tcnt_n      = tcnt;
    err_n       = err_cnt;
    slot_n      = alarm_slot;
    ld_slot_n   = load_slot;
    am_pm_n     = ampm_clr ? 1'b0 : am_pm_q;
    clr_n       = 1'b0;
    ld_time_n   = 1'b0;
    ld_alarm_n  = 1'b0;
    err_pulse_n = 1'b0;
    hm_upd      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_press) begin
          if (is_digit(key_code)) begin
            state_n  = ST_ENTRY;
            digits_n = {12'h000, key_code};
            count_n  = 3'd1;
            tcnt_n   = 4'd0;
            hm_upd   = 1'b1;
          end else if (key_code == KEY_ALARM) begin
            state_n = ST_VIEW;
          end else if (key_code == KEY_NEXT) begin
            slot_n = slot_next;
          end
        end
      end
      ST_VIEW: begin
        if (key_release)                             state_n = ST_IDLE;
        else if (key_press && key_code == KEY_NEXT)  slot_n  = slot_next;
      end
      ST_ENTRY: begin
        if (key_press) begin
          // Any press counts as activity, including one on the expiry cycle.
          tcnt_n = 4'd0;
          if (is_digit(key_code)) begin
            digits_n = {digits[11:0], key_code};
            count_n  = (input_count == 3'd4) ? 3'd4 : input_count + 3'd1;
            hm_upd   = 1'b1;
          end else if (key_code == KEY_BACK) begin
            digits_n = {4'h0, digits[15:4]};
            count_n  = input_count - 3'd1;
            hm_upd   = 1'b1;
            if (input_count == 3'd1) state_n = ST_IDLE;
          end else if (key_code == KEY_AMPM && !mode_24h) begin
            am_pm_n = ~am_pm_q;
          end else if ((key_code == KEY_TIME || key_code == KEY_ALARM) && input_count >= 3'd3) begin
            digits_n = '0;
            count_n  = 3'd0;
            if (entry_valid) begin
              state_n = ST_IDLE;
              clr_n   = 1'b1;
              if (key_code == KEY_TIME) begin
                ld_time_n = 1'b1;
              end else begin
                ld_alarm_n = 1'b1;
                ld_slot_n  = alarm_slot;
              end
            end else begin
              state_n     = ST_ERR;
              err_pulse_n = 1'b1;
              err_n       = 1'b0;
            end
          end
        end else if (tcnt == 4'(TIMEOUT - 1)) begin
          state_n  = ST_IDLE;
          digits_n = '0;
          count_n  = 3'd0;
          tcnt_n   = 4'd0;
          clr_n    = 1'b1;
        end else begin
          tcnt_n = tcnt + 4'd1;
        end
      end
      default: begin
        if (err_cnt) begin
          state_n = ST_IDLE;
          err_n   = 1'b0;
        end else begin
          err_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clock_1sec or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      digits      <= '0;
      input_count <= 3'd0;
      tcnt        <= 4'd0;
      err_cnt     <= 1'b0;
      alarm_slot  <= '0;
      load_slot   <= '0;
      am_pm_q     <= 1'b0;
      ampm_clr    <= 1'b0;
      load_time   <= 1'b0;
      load_alarm  <= 1'b0;
      entry_error <= 1'b0;
      set_hours   <= 5'd0;
      set_mins    <= 6'd0;
    end else begin
      state       <= state_n;
      digits      <= digits_n;
      input_count <= count_n;
      tcnt        <= tcnt_n;
      err_cnt     <= err_n;
      alarm_slot  <= slot_n;
      load_slot   <= ld_slot_n;
      am_pm_q     <= am_pm_n;
      ampm_clr    <= clr_n;
      load_time   <= ld_time_n;
      load_alarm  <= ld_alarm_n;
      entry_error <= err_pulse_n;
      if (hm_upd) begin
        set_hours <= hours_n;
        set_mins  <= mins_n;
      end
    end
  end

  always_comb begin
    case (state)
      ST_IDLE:  display_state = DISP_TIME;
      ST_VIEW:  display_state = DISP_ALARM;
      ST_ENTRY: display_state = DISP_ENTRY;
      default:  display_state = DISP_ERROR;
    endcase
  end

  assign set_secs  = 6'd0;
  assign set_am_pm = am_pm_q & ~mode_24h;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: linear key sequences with hand-computed
// expectations checked by immediate assertions.
module tb_keypad_entry_ctrl;

  logic       Clock_1sec;
  logic       reset;
  logic [3:0] key_code;
  logic       key_held;
  logic       mode_24h;
  logic       load_time, load_alarm, set_am_pm, entry_error;
  logic [2:0] load_slot, alarm_slot, input_count;
  logic [4:0] set_hours;
  logic [5:0] set_mins, set_secs;
  logic [1:0] display_state;

  int errors = 0;
  int checks = 0;

  keypad_entry_ctrl #(.NUM_ALARMS(2), .TIMEOUT(10), .SLOT_W(3)) dut (
    .Clock_1sec   (Clock_1sec),
    .reset        (reset),
    .key_code     (key_code),
    .key_held     (key_held),
    .mode_24h     (mode_24h),
    .load_time    (load_time),
    .load_alarm   (load_alarm),
    .load_slot    (load_slot),
    .alarm_slot   (alarm_slot),
    .set_hours    (set_hours),
    .set_mins     (set_mins),
    .set_secs     (set_secs),
    .set_am_pm    (set_am_pm),
    .display_state(display_state),
    .input_count  (input_count),
    .entry_error  (entry_error)
  );

  // Clock / reset
  initial Clock_1sec = 1'b0;
  always #5 Clock_1sec = ~Clock_1sec;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge Clock_1sec);
    #1;
  endtask

  task automatic press_key(input logic [3:0] k);
    key_code = k;
    key_held = 1'b1;
    tick();
  endtask

  task automatic release_key();
    key_held = 1'b0;
    tick();
  endtask

  task automatic tap(input logic [3:0] k);
    press_key(k);
    release_key();
  endtask

  initial begin
    reset    = 1'b1;
    key_code = 4'h0;
    key_held = 1'b0;
    mode_24h = 1'b0;
    #3;
    check("rst_display", 8'(display_state), 8'd0);
    check("rst_count",   8'(input_count),   8'd0);
    check("rst_slot",    8'(alarm_slot),    8'd0);
    check("rst_hours",   8'(set_hours),     8'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_load_time",  8'(load_time),  8'd0);
    check("post_rst_load_alarm", 8'(load_alarm), 8'd0);

    // 12-hour 12:30 into the time of day
    tap(4'd1); tap(4'd2); tap(4'd3); tap(4'd0);
    check("t1_display_entry", 8'(display_state), 8'd2);
    check("t1_count",         8'(input_count),   8'd4);
    press_key(KEY_B());
    check("t1_load_time",     8'(load_time),     8'd1);
    check("t1_hours",         8'(set_hours),     8'd12);
    check("t1_mins",          8'(set_mins),      8'd30);
    check("t1_am_pm",         8'(set_am_pm),     8'd0);
    check("t1_display_idle",  8'(display_state), 8'd0);
    check("t1_secs",          8'(set_secs),      8'd0);
    release_key();
    check("t1_load_pulse_end", 8'(load_time),    8'd0);

    // AM/PM toggle survives the load cycle and clears the cycle after
    tap(4'd0); tap(4'd9);
    press_key(4'hA);
    check("t2_am_pm_set", 8'(set_am_pm), 8'd1);
    release_key();
    tap(4'd4); tap(4'd5);
    check("t2_hours", 8'(set_hours), 8'd9);
    check("t2_mins",  8'(set_mins),  8'd45);
    press_key(KEY_B());
    check("t2_load_time",   8'(load_time), 8'd1);
    check("t2_am_pm_held",  8'(set_am_pm), 8'd1);
    release_key();
    check("t2_am_pm_clear", 8'(set_am_pm), 8'd0);

    // 24-hour 23:59 into alarm slot 1
    mode_24h = 1'b1;
    tap(4'hE);
    check("t3_slot", 8'(alarm_slot), 8'd1);
    tap(4'd2); tap(4'd3); tap(4'd5); tap(4'd9);
    press_key(4'hC);
    check("t3_load_alarm", 8'(load_alarm), 8'd1);
    check("t3_load_slot",  8'(load_slot),  8'd1);
    check("t3_hours",      8'(set_hours),  8'd23);
    check("t3_mins",       8'(set_mins),   8'd59);
    check("t3_no_time",    8'(load_time),  8'd0);
    release_key();
    check("t3_pulse_end",  8'(load_alarm), 8'd0);

    // 13:00 rejected in 12-hour mode
    mode_24h = 1'b0;
    tap(4'd1); tap(4'd3); tap(4'd0); tap(4'd0);
    press_key(KEY_B());
    check("t4_error",     8'(entry_error),   8'd1);
    check("t4_disp_err1", 8'(display_state), 8'd3);
    check("t4_no_load",   8'(load_time),     8'd0);
    release_key();
    check("t4_error_end", 8'(entry_error),   8'd0);
    check("t4_disp_err2", 8'(display_state), 8'd3);
    tick();
    check("t4_disp_idle", 8'(display_state), 8'd0);

    // Backspace: 9,4,5 -> D leaves 0,0,9,4 (94 minutes, 30 after 6-bit truncation)
    tap(4'd9); tap(4'd4); tap(4'd5);
    check("t5_count3", 8'(input_count), 8'd3);
    tap(4'hD);
    check("t5_count2", 8'(input_count), 8'd2);
    check("t5_mins94", 8'(set_mins),    8'd30);
    check("t5_hours0", 8'(set_hours),   8'd0);
    tap(4'hD); tap(4'hD);
    check("t5_count0", 8'(input_count),   8'd0);
    check("t5_idle",   8'(display_state), 8'd0);

    // Commit with fewer than 3 digits is ignored
    tap(4'd1); tap(4'd2);
    press_key(KEY_B());
    check("t6_no_load", 8'(load_time),     8'd0);
    check("t6_entry",   8'(display_state), 8'd2);
    check("t6_count",   8'(input_count),   8'd2);
    release_key();
    tap(4'hD); tap(4'hD);
    check("t6_idle", 8'(display_state), 8'd0);

    // Timeout: one digit then 10 press-free cycles
    press_key(4'd7);
    check("t7_count1", 8'(input_count), 8'd1);
    key_held = 1'b0;
    repeat (9) tick();
    check("t7_still_entry", 8'(display_state), 8'd2);
    tick();
    check("t7_timeout_idle",  8'(display_state), 8'd0);
    check("t7_timeout_count", 8'(input_count),   8'd0);
    check("t7_no_load",       8'(load_time),     8'd0);

    // Press on the expiry cycle wins
    press_key(4'd7);
    key_held = 1'b0;
    repeat (9) tick();
    press_key(4'd3);
    check("t8_count2", 8'(input_count),   8'd2);
    check("t8_entry",  8'(display_state), 8'd2);
    release_key();
    tap(4'hD); tap(4'hD);

    // Alarm view follows the C key level
    press_key(4'hC);
    check("t9_view", 8'(display_state), 8'd1);
    release_key();
    check("t9_idle", 8'(display_state), 8'd0);

    // Asynchronous reset mid-entry
    tap(4'd1); tap(4'd2); tap(4'd3);
    check("t10_count3", 8'(input_count), 8'd3);
    #2;
    reset = 1'b1;
    #1;
    check("t10_display", 8'(display_state), 8'd0);
    check("t10_count",   8'(input_count),   8'd0);
    check("t10_hours",   8'(set_hours),     8'd0);
    check("t10_mins",    8'(set_mins),      8'd0);
    check("t10_slot",    8'(alarm_slot),    8'd0);
    check("t10_ldslot",  8'(load_slot),     8'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t10_no_load", 8'(load_time | load_alarm), 8'd0);

    // Slot wraps modulo 2
    tap(4'hE); tap(4'hE);
    check("t11_slot_wrap", 8'(alarm_slot), 8'd0);
    tap(4'hE);
    check("t11_slot1",     8'(alarm_slot), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [3:0] KEY_B();
    return 4'hB;
  endfunction

endmodule
